// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared FSM states, FUNCT3 size codes and block geometry for data_cache
package data_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WORD_BITS       = 32;
  localparam int BLOCK_BITS      = 128;
  localparam int WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU-side and memory-side bundles of data_cache
interface data_cache_cpu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  MEMREAD;
  logic                  MEMWRITE;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic [31:0]           WRITEDATA;
  logic [2:0]            FUNCT3;
  logic [31:0]           READDATA;
  logic                  BUSYWAIT;

  modport master (
    output MEMREAD, MEMWRITE, ADDRESS, WRITEDATA, FUNCT3,
    input  READDATA, BUSYWAIT
  );
  modport slave (
    input  MEMREAD, MEMWRITE, ADDRESS, WRITEDATA, FUNCT3,
    output READDATA, BUSYWAIT
  );
endinterface

interface data_cache_mem_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 4
);
  logic                              MEM_READ;
  logic                              MEM_WRITE;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] MEM_ADDRESS;
  logic [127:0]                      MEM_WRITEDATA;
  logic [127:0]                      MEM_READDATA;
  logic                              MEM_BUSYWAIT;

  modport master (
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );
  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/data_cache_load_store_align.sv
// rtl/data_cache_load_store_align.sv - byte-lane extract/extend for loads, lane merge for stores
module load_store_align
  import data_cache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word_i[{byte_off_i, 3'b000} +: 8];
    sel_half = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_o = {24'b0, sel_byte};
      F3_H:    load_o = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_o = {16'b0, sel_half};
      default: load_o = word_i;
    endcase

    store_o = wdata_i;
    case (funct3_i)
      F3_B, F3_BU: begin
        store_o = word_i;
        store_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_H, F3_HU: begin
        store_o = byte_off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                : {word_i[31:16], wdata_i[15:0]};
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate L1 data cache
// Optional hit/miss counters when DATA_CACHE_STATS_EN is defined.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic CLK,
  input  logic RESET,
  data_cache_cpu_if.slave  cpu,
  data_cache_mem_if.master mem
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
`endif
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [31:0]          readdata_q, readdata_d;
  logic [TAG_BITS-1:0]  tag_q [LINES];
  logic [BLOCK_BITS-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag_in;
  logic [1:0]            word_sel;
  logic                  req;
  logic                  hit;
  logic                  read_hit;
  logic [BLOCK_BITS-1:0] cur_block;
  logic [WORD_BITS-1:0]  cur_word;
  logic [WORD_BITS-1:0]  load_word;
  logic [WORD_BITS-1:0]  store_word;

  logic                  line_wr_en;
  logic [BLOCK_BITS-1:0] line_d;
  logic                  tag_wr_en;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] mem_addr;
  logic [BLOCK_BITS-1:0] mem_wdata;

  assign idx       = cpu.ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign tag_in    = cpu.ADDRESS[ADDR_WIDTH-1 -: TAG_BITS];
  assign word_sel  = cpu.ADDRESS[OFFSET_BITS-1:2];
  assign req       = cpu.MEMREAD | cpu.MEMWRITE;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag_in);
  assign cur_block = data_q[idx];
  assign cur_word  = cur_block[{word_sel, 5'b00000} +: WORD_BITS];
  // A simultaneous read+write request is a store, so it never updates READDATA.
  assign read_hit  = (state_q == S_IDLE) && cpu.MEMREAD && !cpu.MEMWRITE && hit;

  load_store_align u_align (
    .word_i     (cur_word),
    .byte_off_i (cpu.ADDRESS[1:0]),
    .funct3_i   (cpu.FUNCT3),
    .wdata_i    (cpu.WRITEDATA),
    .load_o     (load_word),
    .store_o    (store_word)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    readdata_d = readdata_q;
    line_wr_en = 1'b0;
    line_d     = cur_block;
    tag_wr_en  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            if (cpu.MEMWRITE) begin
              line_wr_en = 1'b1;
              line_d[{word_sel, 5'b00000} +: WORD_BITS] = store_word;
              dirty_d[idx] = 1'b1;
            end else begin
              readdata_d = load_word;
            end
          end else begin
            state_d = dirty_q[idx] ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[idx], idx};
        mem_wdata = cur_block;
        if (!mem.MEM_BUSYWAIT) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {tag_in, idx};
        // Refill data is only guaranteed while the memory completes, so capture it here.
        if (!mem.MEM_BUSYWAIT) begin
          line_wr_en = 1'b1;
          line_d     = mem.MEM_READDATA;
          state_d    = S_UPDATE;
        end
      end
      S_UPDATE: begin
        tag_wr_en    = 1'b1;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      readdata_q <= readdata_d;
    end
  end

  // Tags and data need no reset: the cleared valid bits mask them.
  always_ff @(posedge CLK) begin
    if (line_wr_en) data_q[idx] <= line_d;
    if (tag_wr_en)  tag_q[idx]  <= tag_in;
  end

  assign cpu.READDATA      = read_hit ? load_word : readdata_q;
  assign cpu.BUSYWAIT      = RESET && req && (!hit || (state_q != S_IDLE));
  assign mem.MEM_READ      = mem_read;
  assign mem.MEM_WRITE     = mem_write;
  assign mem.MEM_ADDRESS   = mem_addr;
  assign mem.MEM_WRITEDATA = mem_wdata;

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        refill_q, refill_d;

  // The IDLE hit that follows a refill is the same request that already counted as a miss.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    refill_d   = refill_q;
    if (state_q == S_UPDATE) begin
      refill_d = 1'b1;
    end else if (state_q == S_IDLE) begin
      refill_d = 1'b0;
      if (req && hit && !refill_q && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (req && !hit && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      refill_q   <= refill_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
